// File: rtl/snake_engine.sv
// -----------------------------------------------------------------------------
// snake_engine
//
// Game-state core for a grid "snake" game. The snake body lives in a ring
// buffer of cell coordinates (head/tail pointers) mirrored by a one-bit-per-
// cell occupancy bitmap, so both "where is the tail" and "is this cell taken"
// are single lookups. Each tick evaluates one move; eating food triggers a
// pseudo-random search (16-bit LFSR) for a free cell for the next food item.
//
// Ports
//   clk                  single clock, all state changes on the rising edge
//   rst                  synchronous active-high reset (also reseeds the LFSR)
//   restart              synchronous game restart (LFSR keeps running state)
//   tick                 one-cycle move strobe, honoured only while idle
//   up_in/down_in/
//   left_in/right_in     level direction requests
//   query_x/query_y      renderer cell address
//   query_cell           registered cell contents: 00 empty, 01 body,
//                        10 head, 11 food (one cycle after the address)
//   head_x/head_y        current head cell
//   length               snake length in cells
//   score                food eaten, wraps at 16 bits
//   game_over            high while the game is over
//   busy                 high while a move or a food placement is in progress
// -----------------------------------------------------------------------------
module snake_engine #(
    parameter int          GRID_W    = 40,
    parameter int          GRID_H    = 30,
    parameter int          MAX_LEN   = 64,
    parameter int          INIT_LEN  = 3,
    parameter int          WRAP      = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         restart,
    input  logic                         tick,
    input  logic                         up_in,
    input  logic                         down_in,
    input  logic                         left_in,
    input  logic                         right_in,
    input  logic [$clog2(GRID_W)-1:0]    query_x,
    input  logic [$clog2(GRID_H)-1:0]    query_y,
    output logic [1:0]                   query_cell,
    output logic [$clog2(GRID_W)-1:0]    head_x,
    output logic [$clog2(GRID_H)-1:0]    head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic [15:0]                  score,
    output logic                         game_over,
    output logic                         busy
);

    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int LW    = $clog2(MAX_LEN + 1);
    localparam int PW    = $clog2(MAX_LEN);
    localparam int NCELL = GRID_W * GRID_H;
    localparam int CW    = $clog2(NCELL);
    localparam int HX0   = GRID_W / 2;
    localparam int HY0   = GRID_H / 2;
    localparam int FX0   = (3 * GRID_W) / 4;
    localparam int FY0   = GRID_H / 2;

    typedef enum logic [1:0] {S_RUN, S_STEP, S_PLACE, S_OVER} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    // Bitmap contents right after reset: the head cell and the cells to its left.
    function automatic logic [NCELL-1:0] occ_init();
        logic [NCELL-1:0] v;
        v = '0;
        for (int i = 0; i < INIT_LEN; i++) begin
            v[HY0 * GRID_W + HX0 - i] = 1'b1;
        end
        return v;
    endfunction

    localparam logic [NCELL-1:0] OCC_INIT = occ_init();

    function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return CW'(int'(y) * GRID_W + int'(x));
    endfunction

    state_t           state_q, state_d;
    dir_t             dir_q, pend_q, pend_d, commit_dir;
    logic [XW-1:0]    head_x_q, food_x_q;
    logic [YW-1:0]    head_y_q, food_y_q;
    logic [LW-1:0]    len_q;
    logic [15:0]      score_q;
    logic [15:0]      lfsr_q;
    logic [PW-1:0]    head_ptr_q, tail_ptr_q;
    logic [XW-1:0]    ring_x_q [MAX_LEN];
    logic [YW-1:0]    ring_y_q [MAX_LEN];
    logic [NCELL-1:0] occ_q;
    logic [1:0]       query_cell_q, query_cell_d;

    logic [XW-1:0]    nx, tail_x, cand_x;
    logic [YW-1:0]    ny, tail_y, cand_y;
    logic             off_edge, eat, grow, collide, die, place_ok;
    logic             move_en, place_en;
    logic [PW-1:0]    hp_n, tp_n;
    logic [15:0]      lfsr_adv;
    logic [CW-1:0]    head_idx, tail_idx, cand_idx, q_idx;

    // ---------------------------------------------------------------- direction
    // Requests are judged against the direction that will be in force after
    // this cycle, so a request arriving during the commit cycle cannot sneak
    // in a reversal of the freshly committed direction.
    always_comb begin
        commit_dir = (state_q == S_STEP) ? pend_q : dir_q;
        pend_d     = pend_q;
        if (state_q != S_OVER) begin
            if (up_in && commit_dir != D_DOWN) begin
                pend_d = D_UP;
            end else if (down_in && commit_dir != D_UP) begin
                pend_d = D_DOWN;
            end else if (left_in && commit_dir != D_RIGHT) begin
                pend_d = D_LEFT;
            end else if (right_in && commit_dir != D_LEFT) begin
                pend_d = D_RIGHT;
            end
        end
    end

    // ---------------------------------------------------------------- next head
    // The wrapped coordinate is always produced; off_edge decides whether the
    // wrap is legal (WRAP=1) or fatal (WRAP=0).
    always_comb begin
        nx       = head_x_q;
        ny       = head_y_q;
        off_edge = 1'b0;
        case (pend_q)
            D_UP: begin
                if (head_y_q == '0) begin
                    off_edge = 1'b1;
                    ny       = YW'(GRID_H - 1);
                end else begin
                    ny = head_y_q - YW'(1);
                end
            end
            D_DOWN: begin
                if (head_y_q == YW'(GRID_H - 1)) begin
                    off_edge = 1'b1;
                    ny       = '0;
                end else begin
                    ny = head_y_q + YW'(1);
                end
            end
            D_LEFT: begin
                if (head_x_q == '0) begin
                    off_edge = 1'b1;
                    nx       = XW'(GRID_W - 1);
                end else begin
                    nx = head_x_q - XW'(1);
                end
            end
            D_RIGHT: begin
                if (head_x_q == XW'(GRID_W - 1)) begin
                    off_edge = 1'b1;
                    nx       = '0;
                end else begin
                    nx = head_x_q + XW'(1);
                end
            end
        endcase
    end

    assign tail_x   = ring_x_q[tail_ptr_q];
    assign tail_y   = ring_y_q[tail_ptr_q];
    assign head_idx = cell_idx(nx, ny);
    assign tail_idx = cell_idx(tail_x, tail_y);

    assign eat  = (nx == food_x_q) && (ny == food_y_q);
    assign grow = eat && (len_q < LW'(MAX_LEN));
    // The tail cell is free to enter only when it is about to be vacated.
    assign collide = occ_q[head_idx] && !((nx == tail_x) && (ny == tail_y) && !grow);
    assign die     = ((WRAP == 0) && off_edge) || collide;

    assign hp_n = (head_ptr_q == PW'(MAX_LEN - 1)) ? '0 : head_ptr_q + PW'(1);
    assign tp_n = (tail_ptr_q == PW'(MAX_LEN - 1)) ? '0 : tail_ptr_q + PW'(1);

    // ---------------------------------------------------------------- food search
    assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cand_x   = XW'(32'(lfsr_adv) % GRID_W);
    assign cand_y   = YW'(32'(lfsr_adv[15:8]) % GRID_H);
    assign cand_idx = cell_idx(cand_x, cand_y);
    assign place_ok = !occ_q[cand_idx] && !((cand_x == head_x_q) && (cand_y == head_y_q));

    assign move_en  = (state_q == S_STEP) && !die;
    assign place_en = (state_q == S_PLACE) && place_ok;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (tick) state_d = S_STEP;
            S_STEP:  begin
                if (die) begin
                    state_d = S_OVER;
                end else if (eat) begin
                    state_d = S_PLACE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_PLACE: if (place_ok) state_d = S_RUN;
            S_OVER:  state_d = S_OVER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- game state
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            dir_q      <= D_RIGHT;
            pend_q     <= D_RIGHT;
            head_x_q   <= XW'(HX0);
            head_y_q   <= YW'(HY0);
            food_x_q   <= XW'(FX0);
            food_y_q   <= YW'(FY0);
            len_q      <= LW'(INIT_LEN);
            score_q    <= '0;
            head_ptr_q <= PW'(INIT_LEN - 1);
            tail_ptr_q <= '0;
            occ_q      <= OCC_INIT;
            // Entry 0 is the tail, entry INIT_LEN-1 the head.
            for (int i = 0; i < MAX_LEN; i++) begin
                ring_x_q[i] <= (i < INIT_LEN) ? XW'(HX0 - INIT_LEN + 1 + i) : '0;
                ring_y_q[i] <= YW'(HY0);
            end
        end else begin
            pend_q <= pend_d;
            if (move_en) begin
                dir_q          <= pend_q;
                head_ptr_q     <= hp_n;
                ring_x_q[hp_n] <= nx;
                ring_y_q[hp_n] <= ny;
                head_x_q       <= nx;
                head_y_q       <= ny;
                if (grow) begin
                    len_q <= len_q + LW'(1);
                end else begin
                    tail_ptr_q       <= tp_n;
                    occ_q[tail_idx]  <= 1'b0;
                end
                // Placed after the tail clear so a head moving into the
                // vacated tail cell leaves that cell marked occupied.
                occ_q[head_idx] <= 1'b1;
                if (eat) begin
                    score_q <= score_q + 16'd1;
                end
            end
            if (place_en) begin
                food_x_q <= cand_x;
                food_y_q <= cand_y;
            end
        end
    end

    // The LFSR only moves while searching, and a restart leaves it alone so
    // successive games see different food sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (!restart && state_q == S_PLACE) begin
            lfsr_q <= lfsr_adv;
        end
    end

    // ---------------------------------------------------------------- renderer port
    assign q_idx = cell_idx(query_x, query_y);

    always_comb begin
        query_cell_d = 2'b00;
        if (int'(query_x) < GRID_W && int'(query_y) < GRID_H) begin
            if (query_x == head_x_q && query_y == head_y_q) begin
                query_cell_d = 2'b10;
            end else if (occ_q[q_idx]) begin
                query_cell_d = 2'b01;
            end else if (query_x == food_x_q && query_y == food_y_q) begin
                query_cell_d = 2'b11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            query_cell_q <= 2'b00;
        end else begin
            query_cell_q <= query_cell_d;
        end
    end

    assign query_cell = query_cell_q;
    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign length     = len_q;
    assign score      = score_q;
    assign busy       = (state_q == S_STEP) || (state_q == S_PLACE);
    assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_snake_engine.sv
// -----------------------------------------------------------------------------
// tb_snake_engine
//
// Directed scenarios followed by random play against a queue-based model of
// the game rules. Food positions chosen by the engine are discovered by
// scanning the renderer port, which also cross-checks the whole playfield.
// A WRAP=1 instance shares the main stimulus; an INIT_LEN=5 instance has its
// own inputs for the length-5 tail-chase scenario.
// -----------------------------------------------------------------------------
module tb_snake_engine;

    localparam int GW = 40;
    localparam int GH = 30;
    localparam int ML = 64;
    localparam int IL = 3;

    logic       clk = 1'b0;
    logic       rst, restart, tick, up_in, down_in, left_in, right_in;
    logic [5:0] qx;
    logic [4:0] qy;
    logic [1:0] qc, w_qc, f_qc;
    logic [5:0] hx, w_hx, f_hx;
    logic [4:0] hy, w_hy, f_hy;
    logic [6:0] len, w_len, f_len;
    logic [15:0] score, w_score, f_score;
    logic       go, w_go, f_go, busy, w_busy, f_busy;
    logic       restart5, tick5, up5, down5, left5, right5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snake_engine #(.WRAP(0)) dut (
        .clk(clk), .rst(rst), .restart(restart), .tick(tick),
        .up_in(up_in), .down_in(down_in), .left_in(left_in), .right_in(right_in),
        .query_x(qx), .query_y(qy), .query_cell(qc), .head_x(hx), .head_y(hy),
        .length(len), .score(score), .game_over(go), .busy(busy)
    );

    snake_engine #(.WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .restart(restart), .tick(tick),
        .up_in(up_in), .down_in(down_in), .left_in(left_in), .right_in(right_in),
        .query_x(qx), .query_y(qy), .query_cell(w_qc), .head_x(w_hx), .head_y(w_hy),
        .length(w_len), .score(w_score), .game_over(w_go), .busy(w_busy)
    );

    snake_engine #(.INIT_LEN(5)) dut5 (
        .clk(clk), .rst(rst), .restart(restart5), .tick(tick5),
        .up_in(up5), .down_in(down5), .left_in(left5), .right_in(right5),
        .query_x(qx), .query_y(qy), .query_cell(f_qc), .head_x(f_hx), .head_y(f_hy),
        .length(f_len), .score(f_score), .game_over(f_go), .busy(f_busy)
    );

    // ------------------------------------------------------------ reference model
    // Snake as a queue of cells, index 0 = head. Directions: 0 up 1 down 2 left 3 right.
    int sx[$];
    int sy[$];
    int m_dir, m_pend, m_fx, m_fy, m_score, m_over, m_known, m_ate;

    function automatic int ddx(input int d);
        return (d == 2) ? -1 : ((d == 3) ? 1 : 0);
    endfunction

    function automatic int ddy(input int d);
        return (d == 0) ? -1 : ((d == 1) ? 1 : 0);
    endfunction

    task automatic model_reset();
        sx.delete();
        sy.delete();
        for (int i = 0; i < IL; i++) begin
            sx.push_back(GW / 2 - i);
            sy.push_back(GH / 2);
        end
        m_dir = 3; m_pend = 3;
        m_fx = (3 * GW) / 4; m_fy = GH / 2;
        m_score = 0; m_over = 0; m_known = 1; m_ate = 0;
    endtask

    task automatic model_dirs(input bit u, input bit d, input bit l, input bit r);
        bit req [4];
        bit done;
        req  = '{u, d, l, r};
        done = 1'b0;
        if (m_over == 0) begin
            for (int k = 0; k < 4; k++) begin
                if (!done && req[k] && k != (m_dir ^ 1)) begin
                    m_pend = k;
                    done   = 1'b1;
                end
            end
        end
    endtask

    task automatic model_tick();
        int  nx, ny, keep;
        bit  grow, hit;
        m_ate = 0;
        if (m_over != 0) return;
        nx = sx[0] + ddx(m_pend);
        ny = sy[0] + ddy(m_pend);
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            m_over = 1;
            return;
        end
        m_ate = (m_known != 0 && nx == m_fx && ny == m_fy) ? 1 : 0;
        grow  = (m_ate != 0) && (sx.size() < ML);
        keep  = grow ? sx.size() : sx.size() - 1;
        hit   = 1'b0;
        for (int i = 0; i < keep; i++) begin
            if (sx[i] == nx && sy[i] == ny) hit = 1'b1;
        end
        if (hit) begin
            m_over = 1;
            m_ate  = 0;
            return;
        end
        m_dir = m_pend;
        sx.push_front(nx);
        sy.push_front(ny);
        if (!grow) begin
            void'(sx.pop_back());
            void'(sy.pop_back());
        end
        if (m_ate != 0) begin
            m_score = (m_score + 1) % 65536;
            m_known = 0;
        end
    endtask

    function automatic int model_cell(input int x, input int y);
        if (x >= GW || y >= GH) return 0;
        if (x == sx[0] && y == sy[0]) return 2;
        for (int i = 1; i < sx.size(); i++) begin
            if (x == sx[i] && y == sy[i]) return 1;
        end
        if (m_known != 0 && x == m_fx && y == m_fy) return 3;
        return 0;
    endfunction

    // ------------------------------------------------------------ helpers
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_head_x"}, 32'(hx), sx[0]);
        check({tag, "_head_y"}, 32'(hy), sy[0]);
        check({tag, "_length"}, 32'(len), sx.size());
        check({tag, "_score"}, 32'(score), m_score);
        check({tag, "_game_over"}, 32'(go), m_over);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic query(input int x, input int y);
        qx = 6'(x);
        qy = 5'(y);
        cyc();
        check($sformatf("query_%0d_%0d", x, y), 32'(qc), model_cell(x, y));
    endtask

    // Full playfield readback; learns the food cell when it is not yet known.
    task automatic scan();
        int nfood, obs, exp;
        nfood = 0;
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                qx = 6'(x);
                qy = 5'(y);
                cyc();
                obs = int'(qc);
                exp = model_cell(x, y);
                if (m_known == 0 && exp == 0 && obs == 3) begin
                    m_fx = x;
                    m_fy = y;
                    nfood++;
                end else begin
                    check($sformatf("scan_%0d_%0d", x, y), 32'(obs), exp);
                end
            end
        end
        if (m_known == 0) begin
            check("new_food_count", nfood, 1);
            m_known = 1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            cyc();
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic do_dirs(input bit u, input bit d, input bit l, input bit r);
        up_in = u; down_in = d; left_in = l; right_in = r;
        cyc();
        up_in = 0; down_in = 0; left_in = 0; right_in = 0;
        model_dirs(u, d, l, r);
    endtask

    // hold2 keeps tick high into the move cycle; poke pulses tick during PLACE.
    task automatic do_tick(input bit hold2, input bit poke);
        tick = 1;
        cyc();
        if (hold2) begin
            cyc();
            tick = 0;
        end else begin
            tick = 0;
            cyc();
        end
        model_tick();
        check("busy_after_step", 32'(busy), m_ate);
        if (m_ate != 0 && poke) begin
            tick = 1;
            cyc();
            tick = 0;
        end
        wait_idle();
        check_state("step");
        if (m_known == 0) scan();
    endtask

    task automatic do_restart(input bit with_tick);
        restart = 1;
        tick    = with_tick;
        cyc();
        restart = 0;
        tick    = 0;
        model_reset();
        check_state("restart");
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        model_reset();
        check_state("reset");
    endtask

    task automatic move5(input bit u, input bit d, input bit l, input bit r);
        up5 = u; down5 = d; left5 = l; right5 = r;
        cyc();
        up5 = 0; down5 = 0; left5 = 0; right5 = 0;
        tick5 = 1;
        cyc();
        tick5 = 0;
        cyc();
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        rst = 1; restart = 0; tick = 0;
        up_in = 0; down_in = 0; left_in = 0; right_in = 0;
        restart5 = 0; tick5 = 0; up5 = 0; down5 = 0; left5 = 0; right5 = 0;
        qx = 0; qy = 0;
        repeat (3) cyc();
        rst = 0;
        model_reset();

        // Reset state and renderer view.
        check_state("reset");
        query(20, 15); query(19, 15); query(18, 15); query(17, 15);
        query(30, 15); query(40, 15); query(5, 30);

        // Length-5 snake chasing its own body hits a non-tail cell.
        check("len5_init", 32'(f_len), 5);
        move5(1, 0, 0, 0);
        check("len5_up_x", 32'(f_hx), 20);
        check("len5_up_y", 32'(f_hy), 14);
        move5(0, 0, 1, 0);
        check("len5_left_go", 32'(f_go), 0);
        move5(0, 1, 0, 0);
        check("len5_down_go", 32'(f_go), 1);
        check("len5_down_x", 32'(f_hx), 19);
        check("len5_down_y", 32'(f_hy), 14);

        // Five plain moves right, then five more onto the food.
        for (int i = 0; i < 5; i++) do_tick(i[0], 0);
        check("five_ticks_x", 32'(hx), 25);
        query(24, 15); query(25, 15); query(22, 15);
        for (int i = 0; i < 5; i++) do_tick(0, 1);
        check("eat_len", 32'(len), 4);
        check("eat_score", 32'(score), 1);

        // Length 4: loop back into the vacating tail cell.
        do_dirs(1, 0, 0, 0); do_tick(0, 0);
        do_dirs(0, 0, 1, 0); do_tick(0, 0);
        do_dirs(0, 1, 0, 0); do_tick(0, 0);

        // Reverse request ignored, then a legal turn.
        do_reset();
        do_dirs(0, 0, 1, 0); do_tick(0, 0);
        check("reverse_x", 32'(hx), 21);
        do_dirs(1, 0, 0, 0); do_tick(0, 0);
        check("turn_y", 32'(hy), 14);
        // Priority with an opposite request in the mix.
        do_dirs(0, 1, 1, 0); do_tick(0, 0);
        do_dirs(1, 1, 0, 0); do_tick(0, 0);

        // Run into the right edge; the wrapping instance comes out at x=0.
        do_reset();
        for (int i = 0; i < 19; i++) do_tick(0, 0);
        check("edge_19_x", 32'(hx), 39);
        do_tick(0, 0);
        check("edge_go", 32'(go), 1);
        check("edge_hold_x", 32'(hx), 39);
        check("wrap_x", 32'(w_hx), 0);
        check("wrap_y", 32'(w_hy), 15);
        check("wrap_go", 32'(w_go), 0);
        do_tick(0, 0);
        check("over_hold_x", 32'(hx), 39);

        // Restart with tick high, from the game-over state.
        do_restart(1);
        query(19, 15); query(39, 15); query(30, 15);

        // Reset during a move cycle leaves no trace of the move.
        tick = 1;
        cyc();
        tick = 0;
        rst = 1;
        cyc();
        rst = 0;
        model_reset();
        check_state("rst_mid_step");
        query(21, 15); query(20, 15);

        // Random play.
        for (int n = 0; n < 150; n++) begin
            int mask;
            mask = int'($urandom_range(0, 15));
            if (mask != 0) do_dirs(mask[3], mask[2], mask[1], mask[0]);
            do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            query(int'($urandom_range(0, 41)), int'($urandom_range(0, 31)));
            query(sx[sx.size() - 1], sy[sy.size() - 1]);
            if (m_over != 0) do_restart(1'($urandom_range(0, 1)));
        end
        scan();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 Parameter GRID_W, default 40, playfield width in cells.
REQ-002 Parameter GRID_H, default 30, playfield height in cells.
REQ-003 Parameter MAX_LEN, default 64, maximum snake length in cells (at least INIT_LEN+1).
REQ-004 Parameter INIT_LEN, default 3, length after reset/restart.
REQ-005 Parameter WRAP, default 0, meaning 1 = edges wrap around, 0 = edge hit ends the game.
REQ-006 Parameter LFSR_SEED, default 16'hACE1, nonzero seed of the 16-bit food LFSR.
REQ-007 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Ports: restart in 1 (synchronous game restart); tick in 1 (single-cycle move strobe).
REQ-010 Ports: up_in, down_in, left_in, right_in, each input 1 bit (level direction requests).
REQ-011 Ports: query_x in clog2(GRID_W) and query_y in clog2(GRID_H) (renderer cell address).
REQ-012 Port query_cell, output, 2 bits: 00 empty, 01 body, 10 head, 11 food.
REQ-013 Ports: head_x and head_y out, clog2(GRID_W) and clog2(GRID_H) bits (current head cell).
REQ-014 Ports: length out clog2(MAX_LEN+1); score out 16; game_over out 1; busy out 1.

Function
REQ-015 The block SHALL store body positions in a MAX_LEN-entry ring buffer (head and tail pointers) plus a GRID_W*GRID_H occupancy bitmap.
REQ-016 States SHALL be: RUN (await tick), STEP (evaluate move), PLACE (find food cell), OVER.
REQ-017 Direction requests SHALL be latched every cycle into a pending direction with priority up > down > left > right; a request opposite the committed direction SHALL be ignored.
REQ-018 Tick in RUN SHALL go to STEP; in STEP the pending direction is committed and the next head computed; tick outside RUN SHALL be ignored (no queuing).
REQ-019 With WRAP=0, a next head outside 0..GRID_W-1 / 0..GRID_H-1 SHALL go to OVER with the snake unchanged; with WRAP=1 coordinates SHALL wrap modulo GRID_W/GRID_H.
REQ-020 A next head on an occupied cell SHALL go to OVER, except the current tail cell when the move does not grow (tail vacates the same cycle).
REQ-021 A legal non-food move SHALL push the new head, pop the tail, update the bitmap, and return to RUN; the move completes in one STEP cycle.
REQ-022 A move onto food SHALL increment score by 1 (wrapping at 16 bits), skip the tail pop if length < MAX_LEN (length+1), otherwise move normally with length saturated, then go to PLACE.
REQ-023 PLACE SHALL advance the LFSR once per cycle, map it to a candidate cell (x = lfsr mod GRID_W, y = (lfsr>>8) mod GRID_H), accept only an unoccupied, non-head cell, then return to RUN.
REQ-024 busy SHALL be 1 in STEP and PLACE, 0 in RUN and OVER; game_over SHALL be 1 only in OVER.
REQ-025 OVER SHALL hold all state until restart or rst.
REQ-026 query_cell SHALL be registered with 1-cycle latency; priority head > body > food; an out-of-range query SHALL return 00.
REQ-027 restart SHALL act as reset for all state except the LFSR, which continues; restart in any state takes effect next cycle and overrides tick.

Reset
REQ-028 After rst: state RUN, direction right, head (GRID_W/2, GRID_H/2), body occupying the INIT_LEN-1 cells directly left of head.
REQ-029 After rst: length=INIT_LEN, score=0, game_over=0, busy=0, food at (3*GRID_W/4, GRID_H/2), LFSR=LFSR_SEED, bitmap holding only snake cells.
REQ-030 rst asserted mid-STEP or mid-PLACE SHALL abort the operation; no partial update is allowed to persist.

Verification (defaults)
REQ-031 Reset, 5 ticks, no input -> head (25,15), length 3; query (24,15)=01, (25,15)=10, (22,15)=empty.
REQ-032 Reset, left_in held, 1 tick -> head (21,15) (reverse rejected); then up_in, 1 tick -> head (21,14).
REQ-033 Reset, WRAP=0, 20 ticks right -> after 19 head (39,15); the 20th sets game_over=1 and head stays (39,15); WRAP=1 -> head (0,15), no game over.
REQ-034 Reset, 10 ticks -> head (30,15) on food, length 4, score 1, busy high until a new food appears, and the new food is never on a snake cell.
REQ-035 Length 4 (after REQ-034): up, left, down ticks -> head enters the vacated tail cell, game_over=0; same loop at length 5 -> game_over=1.
REQ-036 In OVER, pulse restart with tick high -> next cycle reset state (REQ-028/029, except LFSR), score 0, game_over 0.
